dsp_mac_arbiter: RTL and testbench

DSP_MAC_ARBITER -- requirements
Module: dsp_mac_arbiter

---
 rtl/dsp_mac_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dsp_mac_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_arbiter.sv
// dsp_mac_arbiter
// Two-requester arbiter in front of a 2-stage multiply-accumulate pipeline.
// Each accepted operation computes P = sext38(A << shift) +/- A*B (mod 2^38).
// Stage 1 holds the registered operands and id; stage 2 holds the registered
// result and id, which drive the res_* handshake directly.
// Optional feature: define DSP_MAC_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module dsp_mac_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [19:0] req_a_0,
  input  logic [19:0] req_a_1,
  input  logic [17:0] req_b_0,
  input  logic [17:0] req_b_1,
  input  logic [3:0]  req_shift_0,
  input  logic [3:0]  req_shift_1,
  input  logic        req_sub_0,
  input  logic        req_sub_1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [37:0] res_p,
  output logic        busy
);

  // Stage 1: registered operands
  logic        s1_valid;
  logic        s1_id;
  logic [19:0] s1_a;
  logic [17:0] s1_b;
  logic [3:0]  s1_shift;
  logic        s1_sub;

  // Stage 2: registered result
  logic        s2_valid;
  logic        s2_id;
  logic [37:0] s2_p;

  // Arbitration and handshake
  logic        grant_0;
  logic        grant_1;
  logic        advance;
  logic        s1_open;
  logic        accept;

  // Operand mux feeding stage 1
  logic        sel_id;
  logic [19:0] sel_a;
  logic [17:0] sel_b;
  logic [3:0]  sel_shift;
  logic        sel_sub;

  // Datapath between stage 1 and stage 2
  logic [19:0] shift_term;
  logic [37:0] shift_ext;
  logic [37:0] a_ext;
  logic [37:0] b_ext;
  logic [37:0] product;
  logic [37:0] p_next;

  // Stage 2 drains when empty or when the consumer takes its result.
  assign advance = !s2_valid || res_ready;
  // Stage 1 can take a new operation when empty or when it moves on this edge.
  assign s1_open = !s1_valid || advance;

`ifdef DSP_MAC_ARB_RR_EN
  // Requester granted most recently; reset to 1 so requester 0 goes first.
  logic last_grant;

  // Round-robin grant: on contention the requester not granted last wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_0 = last_grant;
      grant_1 = !last_grant;
    end else begin
      grant_0 = req_valid_0;
      grant_1 = req_valid_1;
    end
  end

  // Pointer moves only when an operation is actually accepted.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= sel_id;
    end
  end
`else
  // Fixed-priority grant: requester 0 always wins on contention.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (req_valid_0) begin
      grant_0 = 1'b1;
    end else if (req_valid_1) begin
      grant_1 = 1'b1;
    end
  end
`endif

  // Ready depends on own valid only through the grant; forced low during reset.
  assign req_ready_0 = reset && grant_0 && s1_open;
  assign req_ready_1 = reset && grant_1 && s1_open;
  assign accept      = (req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1);

  // Select the operands of the granted requester.
  always_comb begin
    sel_id    = 1'b0;
    sel_a     = req_a_0;
    sel_b     = req_b_0;
    sel_shift = req_shift_0;
    sel_sub   = req_sub_0;
    if (grant_1) begin
      sel_id    = 1'b1;
      sel_a     = req_a_1;
      sel_b     = req_b_1;
      sel_shift = req_shift_1;
      sel_sub   = req_sub_1;
    end
  end

  // Stage 1 valid: fill on accept, empty when its contents move to stage 2.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 1 operand capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: operand registers carry no reset; they are qualified by s1_valid, which is reset.
    if (accept) begin
      s1_id    <= sel_id;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_shift <= sel_shift;
      s1_sub   <= sel_sub;
    end
  end

  // Shift term truncated to 20 bits, then sign-extended; product of
  // sign-extended operands keeps the low 38 bits of the signed product.
  assign shift_term = s1_a << s1_shift;
  assign shift_ext  = {{18{shift_term[19]}}, shift_term};
  assign a_ext      = {{18{s1_a[19]}}, s1_a};
  assign b_ext      = {{20{s1_b[17]}}, s1_b};
  assign product    = a_ext * b_ext;
  assign p_next     = s1_sub ? (shift_ext - product) : (shift_ext + product);

  // Stage 2: load from stage 1 on advance, otherwise hold the presented result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_p     <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id <= s1_id;
        s2_p  <= p_next;
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_id    = s2_id;
  assign res_p     = s2_p;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_dsp_mac_arbiter.sv
// tb_dsp_mac_arbiter
// Directed and random checks of dsp_mac_arbiter with a result scoreboard.
// Build with +define+DSP_MAC_ARB_RR_EN to check the round-robin variant.
module tb_dsp_mac_arbiter;

  logic        clk;
  logic        reset;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [19:0] req_a_0, req_a_1;
  logic [17:0] req_b_0, req_b_1;
  logic [3:0]  req_shift_0, req_shift_1;
  logic        req_sub_0, req_sub_1;
  logic        res_valid;
  logic        res_ready;
  logic        res_id;
  logic [37:0] res_p;
  logic        busy;

  typedef struct {
    logic        id;
    logic [37:0] p;
  } exp_t;

  exp_t exp_q[$];
  logic id_log[$];
  int   errors = 0;
  int   checks = 0;
  logic acc0, acc1;

  dsp_mac_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_a_0     (req_a_0),
    .req_a_1     (req_a_1),
    .req_b_0     (req_b_0),
    .req_b_1     (req_b_1),
    .req_shift_0 (req_shift_0),
    .req_shift_1 (req_shift_1),
    .req_sub_0   (req_sub_0),
    .req_sub_1   (req_sub_1),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_p       (res_p),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: S = A<<shift truncated to 20 bits (signed), P = S +/- A*B mod 2^38.
  function automatic logic [37:0] model(input logic [19:0] a, input logic [17:0] b,
                                        input logic [3:0] sh, input logic sub);
    logic [19:0] s;
    longint      sv, av, bv, r;
    s  = a << sh;
    sv = longint'($signed(s));
    av = longint'($signed(a));
    bv = longint'($signed(b));
    r  = sub ? (sv - av * bv) : (sv + av * bv);
    return r[37:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: sample handshakes away from the edge, update scoreboard, cross the edge.
  task automatic step();
    exp_t e;
    #1;
    acc0 = req_valid_0 && req_ready_0;
    acc1 = req_valid_1 && req_ready_1;
    check("one_ready", 64'(req_ready_0 && req_ready_1), 64'd0);
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(res_p), 64'hdead);
      end else begin
        e = exp_q.pop_front();
        check("sb_res_id", 64'(res_id), 64'(e.id));
        check("sb_res_p", 64'(res_p), 64'(e.p));
        id_log.push_back(res_id);
      end
    end
    if (acc0) exp_q.push_back('{id: 1'b0, p: model(req_a_0, req_b_0, req_shift_0, req_sub_0)});
    if (acc1) exp_q.push_back('{id: 1'b1, p: model(req_a_1, req_b_1, req_shift_1, req_sub_1)});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one operation on a requester until accepted (bounded), then withdraw it.
  task automatic send(input logic id, input logic [19:0] a, input logic [17:0] b,
                      input logic [3:0] sh, input logic sub);
    int budget;
    budget = 0;
    if (id) begin
      req_a_1 = a; req_b_1 = b; req_shift_1 = sh; req_sub_1 = sub; req_valid_1 = 1'b1;
    end else begin
      req_a_0 = a; req_b_0 = b; req_shift_0 = sh; req_sub_0 = sub; req_valid_0 = 1'b1;
    end
    do begin
      step();
      budget++;
    end while (!(id ? acc1 : acc0) && budget < 20);
    check("send_accepted", 64'(id ? acc1 : acc0), 64'd1);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
  endtask

  // Let every outstanding result leave (bounded), then expect an idle pipeline.
  task automatic drain();
    int budget;
    budget = 0;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    res_ready   = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && budget < 50) begin
      step();
      budget++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    int n0, n1, budget, k;

    reset = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_a_0 = '0; req_b_0 = '0; req_shift_0 = '0; req_sub_0 = 1'b0;
    req_a_1 = '0; req_b_1 = '0; req_shift_1 = '0; req_sub_1 = 1'b0;
    res_ready = 1'b1;
    acc0 = 1'b0; acc1 = 1'b0;

    // Reset state, with both requesters asking
    #3;
    check("rst_ready_0", 64'(req_ready_0), 64'd0);
    check("rst_ready_1", 64'(req_ready_1), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_p", 64'(res_p), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    @(negedge clk);
    @(negedge clk);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    reset = 1'b1;

    // Requester 0: 20 - 10 = 10, visible one edge after acceptance
    send(1'b0, 20'd5, 18'd2, 4'd2, 1'b1);
    step();
    check("r0_valid", 64'(res_valid), 64'd1);
    check("r0_p", 64'(res_p), 64'd10);
    check("r0_id", 64'(res_id), 64'd0);
    drain();

    // Requester 1: 20 + 10 = 30
    send(1'b1, 20'd5, 18'd2, 4'd2, 1'b0);
    step();
    check("r1_valid", 64'(res_valid), 64'd1);
    check("r1_p", 64'(res_p), 64'd30);
    check("r1_id", 64'(res_id), 64'd1);
    drain();

    // Shift term truncates to 0: result is just A*B = 262144
    send(1'b1, 20'h40000, 18'd1, 4'd2, 1'b0);
    step();
    check("trunc_p", 64'(res_p), 64'd262144);
    check("trunc_id", 64'(res_id), 64'd1);
    drain();

    // Contention for 8 cycles; last grant was requester 1
    req_a_0 = 20'd3; req_b_0 = 18'd3; req_shift_0 = 4'd0; req_sub_0 = 1'b0;
    req_a_1 = 20'd7; req_b_1 = 18'd7; req_shift_1 = 4'd1; req_sub_1 = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    id_log.delete();
    repeat (8) step();
    drain();
    check("arb_count", 64'(id_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < id_log.size(); i++) begin
`ifdef DSP_MAC_ARB_RR_EN
      check($sformatf("arb_id_%0d", i), 64'(id_log[i]), 64'(i % 2));
`else
      check($sformatf("arb_id_%0d", i), 64'(id_log[i]), 64'd0);
`endif
    end

    // Backpressure: stream, stall 3 cycles, release, nothing lost or duplicated
    res_ready = 1'b1;
    req_valid_0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a_0 = 20'(i + 11); req_b_0 = 18'(i + 2); req_shift_0 = 4'(i); req_sub_0 = i[0];
      step();
    end
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", 64'(res_valid), 64'd1);
      check("stall_p", 64'(res_p), 64'(exp_q[0].p));
      check("stall_id", 64'(res_id), 64'(exp_q[0].id));
      check("stall_ready", 64'(req_ready_0), 64'd0);
      step();
    end
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_a_0 = 20'(i + 40); req_b_0 = 18'(i + 5); req_shift_0 = 4'(i + 3); req_sub_0 = 1'b1;
      step();
    end
    drain();

    // Reset with both stages full
    res_ready = 1'b0;
    req_valid_0 = 1'b1;
    req_a_0 = 20'd9; req_b_0 = 18'd9; req_shift_0 = 4'd1; req_sub_0 = 1'b0;
    repeat (3) step();
    #1;
    check("full_busy", 64'(busy), 64'd1);
    check("full_valid", 64'(res_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_p", 64'(res_p), 64'd0);
    check("mid_rst_ready", 64'(req_ready_0), 64'd0);
    exp_q.delete();
    @(negedge clk);
    res_ready = 1'b1;
    req_a_0 = 20'hfffff; req_b_0 = 18'h3ffff; req_shift_0 = 4'd15; req_sub_0 = 1'b1;
    reset = 1'b1;
    step();
    check("post_rst_accept", 64'(acc0), 64'd1);
    req_valid_0 = 1'b0;
    drain();

    // Random operations: 32 per requester, negatives and shift=15 forced periodically
    n0 = 0; n1 = 0; budget = 0; k = 0;
    while ((n0 < 32 || n1 < 32) && budget < 2000) begin
      r = $urandom;
      req_valid_0 = (n0 < 32) && (r[1:0] != 2'd0);
      req_valid_1 = (n1 < 32) && (r[3:2] != 2'd0);
      res_ready   = (r[5:4] != 2'd0);
      r = $urandom;
      req_a_0 = (k % 5 == 0) ? (r[19:0] | 20'h80000) : r[19:0];
      r = $urandom;
      req_b_0 = (k % 3 == 0) ? (r[17:0] | 18'h20000) : r[17:0];
      req_shift_0 = (k % 4 == 0) ? 4'd15 : r[21:18];
      req_sub_0 = r[22];
      r = $urandom;
      req_a_1 = (k % 5 == 1) ? (r[19:0] | 20'h80000) : r[19:0];
      r = $urandom;
      req_b_1 = (k % 3 == 1) ? (r[17:0] | 18'h20000) : r[17:0];
      req_shift_1 = (k % 4 == 1) ? 4'd15 : r[21:18];
      req_sub_1 = r[22];
      step();
      if (acc0) n0++;
      if (acc1) n1++;
      budget++;
      k++;
    end
    check("rand_count_0", 64'(n0), 64'd32);
    check("rand_count_1", 64'(n1), 64'd32);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
